// File: rtl/axis_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter that feeds one AXI-Stream transmitter from
// NUM_REQ producers; it forces tlast at MAX_BEATS and counts forwarded frames.
module axis_tx_frame_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BEATS  = 400,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          tx_vld,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_last,
  input  logic                          tx_rdy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic [31:0]                   frame_cnt,
  output logic                          trunc_pulse
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_WIDTH-1:0] GRANT_RST = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d, pick, cand;
  logic                    pick_found;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [31:0]             frame_cnt_q, frame_cnt_d;
  logic                    trunc_q, trunc_d;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   req_beat [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign req_beat[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the last grant, so the just-served requester comes last.
  always_comb begin
    pick       = grant_q;
    pick_found = 1'b0;
    cand       = grant_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(grant_q) + k) % NUM_REQ);
      if (!pick_found && req_vld[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    trunc_d     = 1'b0;
    req_rdy     = '0;
    tx_vld      = 1'b0;
    tx_data     = '0;
    tx_last     = 1'b0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = LOCK;
          grant_d    = pick;
          beat_cnt_d = '0;
        end
      end
      LOCK: begin
        tx_vld           = req_vld[grant_q];
        tx_data          = req_beat[grant_q];
        tx_last          = req_last[grant_q] | (beat_cnt_q == LAST_BEAT);
        req_rdy[grant_q] = tx_rdy;
        xfer             = tx_vld & tx_rdy;
        if (xfer) begin
          if (tx_last) begin
            // Forced end: the producer's remaining beats become a new frame later.
            state_d     = IDLE;
            frame_cnt_d = frame_cnt_q + 32'd1;
            trunc_d     = ~req_last[grant_q];
            beat_cnt_d  = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_RST;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_q     <= trunc_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q == LOCK);
  assign frame_cnt   = frame_cnt_q;
  assign trunc_pulse = trunc_q;

endmodule
